// File: rtl/avalon_pio_bank.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pio_bank
// Brief    : Avalon-MM PIO bank with NUM_OUT output channel registers and an
//            IN_W-bit input port with synchroniser, debounce, edge capture
//            and a maskable level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_pio_bank #(
   parameter int NUM_OUT   = 3,
   parameter int OUT_W     = 16,
   parameter int IN_W      = 2,
   parameter int DEB_CYC   = 50000,
   parameter int EDGE_MODE = 0,
   parameter int ADDR_W    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        address,
   input  logic                     read,
   input  logic                     write,
   input  logic [31:0]              writedata,
   output logic [31:0]              readdata,
   output logic                     irq,
   input  logic [IN_W-1:0]          in_export,
   output logic [NUM_OUT*OUT_W-1:0] out_export
);

   localparam int                 c_CNT_W     = $clog2(DEB_CYC + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(DEB_CYC - 1);
   localparam logic [ADDR_W-1:0]  c_ADDR_IN   = ADDR_W'(NUM_OUT);
   localparam logic [ADDR_W-1:0]  c_ADDR_EDGE = ADDR_W'(NUM_OUT + 1);
   localparam logic [ADDR_W-1:0]  c_ADDR_MASK = ADDR_W'(NUM_OUT + 2);

   logic [OUT_W-1:0] r_out [NUM_OUT];
   logic [IN_W-1:0]  r_sync1;
   logic [IN_W-1:0]  r_sync2;
   logic [IN_W-1:0]  r_deb;
   logic [IN_W-1:0]  w_deb_next;
   logic [IN_W-1:0]  r_edge;
   logic [IN_W-1:0]  r_mask;
   logic [IN_W-1:0]  w_edge_set;
   logic [IN_W-1:0]  w_edge_clr;
   logic [31:0]      w_rd_mux;
   logic [31:0]      r_readdata;
   logic             r_irq;
   logic             w_unused_wdata;

   // Upper writedata bits are architecturally ignored.
   assign w_unused_wdata = ^writedata;

   // Output channel registers, written by word address 0..NUM_OUT-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            r_out[k] <= '0;
         end
      end else if (write) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (address == ADDR_W'(k)) begin
               r_out[k] <= writedata[OUT_W-1:0];
            end
         end
      end
   end

   generate
      for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
         assign out_export[k*OUT_W +: OUT_W] = r_out[k];
      end
   endgenerate

   // Two-flop synchroniser and debounced value register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
      end else begin
         r_sync1 <= in_export;
         r_sync2 <= r_sync1;
         r_deb   <= w_deb_next;
      end
   end

   generate
      for (genvar i = 0; i < IN_W; i++) begin : g_deb
         logic [c_CNT_W-1:0] r_cnt;
         logic               w_mismatch;

         assign w_mismatch    = (r_sync2[i] != r_deb[i]);
         // The bit flips on the DEB_CYC-th consecutive mismatched cycle.
         assign w_deb_next[i] = (w_mismatch && (r_cnt == c_CNT_LAST)) ? r_sync2[i] : r_deb[i];

         // Stability counter: cleared on match or on acceptance of a new value.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_cnt <= '0;
            end else if (!w_mismatch || (r_cnt == c_CNT_LAST)) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + c_CNT_W'(1);
            end
         end
      end
   endgenerate

   // Select which debounced transitions count as edges.
   always_comb begin
      w_edge_set = '0;
      case (EDGE_MODE)
         0:       w_edge_set = w_deb_next & ~r_deb;
         1:       w_edge_set = ~w_deb_next & r_deb;
         default: w_edge_set = w_deb_next ^ r_deb;
      endcase
   end

   assign w_edge_clr = (write && (address == c_ADDR_EDGE)) ? writedata[IN_W-1:0] : '0;

   // Edge capture (set beats write-1-clear), mask register and registered irq.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_edge <= '0;
         r_mask <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_edge <= (r_edge & ~w_edge_clr) | w_edge_set;
         if (write && (address == c_ADDR_MASK)) begin
            r_mask <= writedata[IN_W-1:0];
         end
         r_irq <= |(r_edge & r_mask);
      end
   end

   // Read data multiplexer; unmapped addresses return zero.
   always_comb begin
      w_rd_mux = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (address == ADDR_W'(k)) begin
            w_rd_mux = 32'(r_out[k]);
         end
      end
      if (address == c_ADDR_IN) begin
         w_rd_mux = 32'(r_deb);
      end
      if (address == c_ADDR_EDGE) begin
         w_rd_mux = 32'(r_edge);
      end
      if (address == c_ADDR_MASK) begin
         w_rd_mux = 32'(r_mask);
      end
   end

   // Latency-1 read data register; holds between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_readdata <= '0;
      end else if (read) begin
         r_readdata <= w_rd_mux;
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule
`default_nettype wire
